// File: rtl/counter_burst_sequencer_pkg.sv
// Shared definitions for the burst sequencer: default sizes, state encoding and
// the gap-timer width helper.
package counter_burst_sequencer_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefRepW  = 4;
    localparam int unsigned DefGap   = 2;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StGap   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    // A zero-cycle gap still needs a 1-bit timer so that no vector collapses to zero width.
    function automatic int unsigned timer_width(input int unsigned gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/counter_burst_gap_timer.sv
// Inter-burst gap timer: loads GAP-1, counts down to zero and flags zero.
module counter_burst_gap_timer
    import counter_burst_sequencer_pkg::*;
#(
    parameter int unsigned GAP = DefGap
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned TW = timer_width(GAP);
    localparam logic [TW-1:0] LoadVal = TW'((GAP > 0) ? GAP - 1 : 0);

    logic [TW-1:0] timer_d, timer_q;

    always_comb begin
        timer_d = timer_q;
        if (load_i) begin
            timer_d = LoadVal;
        end else if (dec_i && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign zero_o = (timer_q == '0);

endmodule

// File: rtl/counter_burst_sequencer.sv
// Drives an external enable counter through a number of clear/count-to-target bursts
// separated by a fixed idle gap.
module counter_burst_sequencer
    import counter_burst_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned REP_W = DefRepW,
    parameter int unsigned GAP   = DefGap
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] target,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic             abort,
    input  logic [WIDTH-1:0] ctr_value,
    output logic             ctr_reset,
    output logic             ctr_enable,
    output logic             busy,
    output logic             burst_done,
    output logic             all_done,
    output logic [REP_W-1:0] bursts_left
);

    logic [2:0]       state_d, state_q;
    logic [REP_W-1:0] bursts_left_d, bursts_left_q;
    logic [WIDTH-1:0] target_d, target_q;
    logic             timer_load, timer_dec, timer_zero;
    logic             hit;

    assign hit = (ctr_value == target_q);

    always_comb begin
        state_d       = state_q;
        bursts_left_d = bursts_left_q;
        target_d      = target_q;
        timer_load    = 1'b0;
        timer_dec     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_valid) begin
                    target_d      = target;
                    bursts_left_d = repeat_cnt;
                    state_d       = (repeat_cnt == '0) ? StDone : StClear;
                end
            end
            StClear: state_d = StRun;
            StRun: begin
                if (hit) begin
                    bursts_left_d = bursts_left_q - 1'b1;
                    if (bursts_left_q == REP_W'(1)) begin
                        state_d = StDone;
                    end else if (GAP == 0) begin
                        state_d = StClear;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = StGap;
                    end
                end
            end
            StGap: begin
                if (timer_zero) begin
                    state_d = StClear;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort wins over everything once a command is in flight; the counter is left as is.
        if (abort && (state_q != StIdle)) begin
            state_d       = StIdle;
            bursts_left_d = '0;
            timer_load    = 1'b0;
            timer_dec     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            bursts_left_q <= '0;
            target_q      <= '0;
        end else begin
            state_q       <= state_d;
            bursts_left_q <= bursts_left_d;
            target_q      <= target_d;
        end
    end

    counter_burst_gap_timer #(
        .GAP (GAP)
    ) u_gap_timer (
        .clk_i  (clock),
        .rst_ni (reset),
        .load_i (timer_load),
        .dec_i  (timer_dec),
        .zero_o (timer_zero)
    );

    // Enable is Mealy on the live counter value so counting stops exactly at target.
    assign start_ready = (state_q == StIdle);
    assign busy        = reset && (state_q != StIdle);
    assign ctr_reset   = (state_q == StClear) || !reset;
    assign ctr_enable  = reset && (state_q == StRun) && !hit && !abort;
    assign burst_done  = reset && (state_q == StRun) && hit && !abort;
    assign all_done    = reset && (state_q == StDone) && !abort;
    assign bursts_left = bursts_left_q;

endmodule

// File: tb/tb_counter_burst_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit enable counter.
module tb_counter_burst_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] target;
    logic [3:0] repeat_cnt;
    logic       abort;
    logic [3:0] ctr_value;
    logic       ctr_reset;
    logic       ctr_enable;
    logic       busy;
    logic       burst_done;
    logic       all_done;
    logic [3:0] bursts_left;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    // The team's existing enable counter.
    always_ff @(posedge clock) begin
        if (ctr_reset) ctr_value <= 4'd0;
        else if (ctr_enable) ctr_value <= ctr_value + 4'd1;
    end

    counter_burst_sequencer #(
        .WIDTH (4),
        .REP_W (4),
        .GAP   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .target      (target),
        .repeat_cnt  (repeat_cnt),
        .abort       (abort),
        .ctr_value   (ctr_value),
        .ctr_reset   (ctr_reset),
        .ctr_enable  (ctr_enable),
        .busy        (busy),
        .burst_done  (burst_done),
        .all_done    (all_done),
        .bursts_left (bursts_left)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept a command at the next edge (cycle 0) and watch it until all_done or budget.
    task automatic run_cmd(input logic [3:0] tgt, input logic [3:0] rep,
                           output int en, output int clr, output int bd, output int gap,
                           output int bd_first, output int done_cyc,
                           output logic [11:0] bl_seq, output logic over);
        int cyc;
        en = 0; clr = 0; bd = 0; gap = 0; bd_first = -1; done_cyc = -1;
        bl_seq = '0; over = 1'b0;
        start_valid = 1'b1; target = tgt; repeat_cnt = rep;
        tick();
        start_valid = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            if (ctr_enable) en++;
            if (ctr_reset) clr++;
            if (busy && !ctr_reset && (ctr_value > tgt)) over = 1'b1;
            if (burst_done) begin
                bd++;
                if (bd_first < 0) bd_first = cyc;
                bl_seq = {bl_seq[7:0], bursts_left};
            end
            if (busy && !ctr_reset && !ctr_enable && !burst_done && !all_done) gap++;
            if (all_done) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        int en, clr, bd, gap, bd_first, done_cyc;
        logic [11:0] bl_seq;
        logic over;

        reset = 1'b0; start_valid = 1'b0; abort = 1'b0;
        target = '0; repeat_cnt = '0;

        // 1. Reset
        tick(); tick(); tick();
        check("rst_ctr_reset", ctr_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_enable", ctr_enable, 0);
        reset = 1'b1;
        tick();
        check("post_rst_ready", start_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_bl", bursts_left, 0);

        // 2. target=5, repeat=1
        run_cmd(4'd5, 4'd1, en, clr, bd, gap, bd_first, done_cyc, bl_seq, over);
        check("t5_en", en, 5);
        check("t5_bd_cyc", bd_first, 7);
        check("t5_done_cyc", done_cyc, 8);
        check("t5_bd_cnt", bd, 1);
        tick();
        check("t5_ready", start_ready, 1);
        check("t5_ctr", ctr_value, 5);

        // 3. target=3, repeat=3, two gap cycles between bursts
        run_cmd(4'd3, 4'd3, en, clr, bd, gap, bd_first, done_cyc, bl_seq, over);
        check("r3_en", en, 9);
        check("r3_clr", clr, 3);
        check("r3_bd", bd, 3);
        check("r3_gap", gap, 4);
        check("r3_bl_seq", bl_seq, 12'h321);
        check("r3_done_cyc", done_cyc, 20);
        check("r3_over", over, 0);
        tick();
        check("r3_bl_end", bursts_left, 0);

        // 4. target=0, repeat=2; then repeat=0
        run_cmd(4'd0, 4'd2, en, clr, bd, gap, bd_first, done_cyc, bl_seq, over);
        check("z_en", en, 0);
        check("z_bd", bd, 2);
        check("z_bd_cyc", bd_first, 2);
        check("z_done_cyc", done_cyc, 7);
        tick();
        run_cmd(4'd7, 4'd0, en, clr, bd, gap, bd_first, done_cyc, bl_seq, over);
        check("r0_done_cyc", done_cyc, 1);
        check("r0_clr", clr, 0);
        check("r0_bd", bd, 0);
        tick();
        check("r0_ready", start_ready, 1);

        // 5. target=15, no wrap
        run_cmd(4'd15, 4'd1, en, clr, bd, gap, bd_first, done_cyc, bl_seq, over);
        check("t15_en", en, 15);
        check("t15_done_cyc", done_cyc, 18);
        tick(); tick(); tick();
        check("t15_hold", ctr_value, 15);

        // 6a. abort at counter=2 of target=9
        start_valid = 1'b1; target = 4'd9; repeat_cnt = 4'd1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 20 && ctr_value != 4'd2; i++) tick();
        check("ab_reach2", ctr_value, 2);
        abort = 1'b1;
        #1;
        check("ab_enable", ctr_enable, 0);
        check("ab_bd", burst_done, 0);
        tick();
        abort = 1'b0;
        check("ab_idle", start_ready, 1);
        check("ab_busy", busy, 0);
        check("ab_bl", bursts_left, 0);
        check("ab_alldone", all_done, 0);
        tick(); tick();
        check("ab_frozen", ctr_value, 2);
        run_cmd(4'd3, 4'd1, en, clr, bd, gap, bd_first, done_cyc, bl_seq, over);
        check("ab_new_en", en, 3);
        check("ab_new_done", done_cyc, 6);
        check("ab_new_over", over, 0);
        tick();
        check("ab_new_ctr", ctr_value, 3);

        // 6b. reset mid-RUN
        start_valid = 1'b1; target = 4'd9; repeat_cnt = 4'd2;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 20 && ctr_value != 4'd2; i++) tick();
        check("mr_reach2", ctr_value, 2);
        reset = 1'b0;
        #1;
        check("mr_ctr_reset", ctr_reset, 1);
        check("mr_enable", ctr_enable, 0);
        check("mr_busy", busy, 0);
        tick();
        reset = 1'b1;
        #1;
        check("mr_idle", start_ready, 1);
        check("mr_bl", bursts_left, 0);
        check("mr_alldone", all_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
